spi_flash_arbiter: RTL and testbench
====================================

# spi_flash_arbiter

Shares the single SPI byte engine and flash chip-select between two requesters: requester 0 is the boot sequencer and requester 1 is the runtime flash-read path. Arbitration is per transaction. A requester holds the engine from the moment its chip-select request goes low until it releases it. A start strobe issued before grant is captured and replayed, so requesters that do not watch `gnt` still work. A programmable deselect gap enforces flash CS# high time between transactions.

## Interface
Parameters:
- `CSB_HIGH_CYCLES`, default 2: minimum cycles `flash_csb_o` stays high between transactions. Legal range is 1..255.
- `FIXED_PRIO`, default 1: selects the tie-break rule.
  - 1: requester 0 always wins ties.
  - 0: round-robin; a tie goes to the requester not served last.

Ports:
- `clk_i`  in  1  sole clock, rising edge.
- `reset_i`  in  1  reset, synchronous and active-high.
- `rN_csb_i`  in  1  requester N (N=0,1) transaction request, active low.
- `rN_spi_start_i`  in  1  requester N byte-start strobe (1 cycle).
- `rN_spi_out_i`  in  8  requester N byte to transmit, valid with its start.
- `rN_spi_in_o`  out  8  received byte, a copy of `spi_in_i`.
- `rN_spi_done_o`  out  1  byte complete for requester N.
- `rN_spi_busy_o`  out  1  byte pending or in flight for requester N.
- `rN_gnt_o`  out  1  requester N owns the engine.
- `spi_start_o`  out  1  start to the SPI byte engine.
- `spi_out_o`  out  8  byte to the engine; the engine captures it in the start cycle.
- `spi_in_i`  in  8  engine receive byte, valid with `spi_done_i`.
- `spi_done_i`  in  1  engine byte-complete pulse.
- `spi_busy_i`  in  1  engine shifting.
- `flash_csb_o`  out  1  flash chip-select, active low.

## Operation
FSM states: IDLE, GNT0, GNT1, GAP.
- Request definition: `reqN = ~rN_csb_i`, sampled each cycle.
- IDLE:
  - `flash_csb_o`=1.
  - Only one `reqN` active → GNTN next cycle.
  - Both active → tie-break per `FIXED_PRIO`.
  - `last` register records the requester served; reset value 1, so requester 0 wins the first round-robin tie.
- GNTN:
  - `flash_csb_o`=0, `rN_gnt_o`=1.
  - `spi_start_o`/`spi_out_o` are driven from requester N's pending byte if one is held, otherwise passed through from `rN_spi_start_i`/`rN_spi_out_i` combinationally.
  - `rN_spi_done_o` = `spi_done_i`.
  - Exit condition: `rN_csb_i` high, `spi_busy_i` low, no pending start, and no start this cycle → GAP, with the gap counter loaded to `CSB_HIGH_CYCLES`−1.
  - `rN_csb_i` rising mid-byte: stay in GNTN until `spi_done_i`. Done is still delivered to N, then the FSM goes to GAP.
- GAP:
  - `flash_csb_o`=1; the counter decrements each cycle.
  - Counter==0 → IDLE.
  - Requests during GAP are held, not lost.
- Pending-start capture, per requester:
  - `rN_spi_start_i` while the state is not GNTN sets `pendN` and latches `rN_spi_out_i` into `pbyteN`.
  - On the first GNTN cycle, `spi_start_o`=1 with `pbyteN`; `pendN` clears at that edge.
  - A second start while `pendN` is set is ignored; the first byte is retained.
  - `rN_csb_i` high while `pendN` is set and not granted → `pendN` cleared (abort).
- Busy/done rules:
  - `rN_spi_busy_o` = `pendN` | (GNTN & (`spi_busy_i` | `spi_start_o`)).
  - The non-owner's `spi_done_o`=0.
  - `rN_spi_in_o` = `spi_in_i` at all times; it is meaningful only with done.
- Unused-path values: `spi_out_o`=0 whenever `spi_start_o`=0.

## Timing
- Reset values (effective at the first edge with `reset_i`=1):
  - State IDLE; `pend0`/`pend1`=0; `pbyte0`/`pbyte1`=0; counter=0; `last`=1.
  - Outputs: `flash_csb_o`=1; `spi_start_o`=0; `spi_out_o`=0; `gnt`/`done`/`busy`=0.
- Reset mid-transaction: `flash_csb_o` goes high at the next edge; an in-flight engine byte is abandoned and no done is forwarded.
- Grant latency: request first sampled at edge t → GNTN and `gnt`/`flash_csb_o`=0 during cycle t+1.
- Start issued in cycle t with the request → replayed on `spi_start_o` in cycle t+1 (one-cycle latency). A start issued while already granted has zero latency.
- Done passes through to the owner with zero latency.
- Release: `rN_csb_i` high in cycle r with the engine idle → `flash_csb_o` high from cycle r+1 for exactly `CSB_HIGH_CYCLES` cycles. An earliest competing grant appears at r+1+`CSB_HIGH_CYCLES`.
- All outputs are decoded from registered state and registered pend state; the pass-through paths are combinational.

## Test plan
- **Boot alone.** `r0_csb_i`↓ with start, byte 0x03 in the same cycle.
  - `spi_start_o`=1 with 0x03 one cycle later; `r0_gnt_o`=1.
  - `spi_done_i` → `r0_spi_done_o`=1, `r0_spi_in_o`=`spi_in_i`.
- **Simultaneous requests, `FIXED_PRIO`=1.**
  - Requester 0 is granted; `r1_spi_busy_o`=1 while its start is pending.
  - After r0 releases: `flash_csb_o` high for exactly 2 cycles, then GNT1 and r1's pending byte 0xA5 is replayed.
- **Round-robin, `FIXED_PRIO`=0.** Both requesters hold requests continuously across three transactions → grant order 0,1,0.
- **Release mid-byte.** `r1_csb_i`↑ while `spi_busy_i`=1 → `flash_csb_o` stays 0 until `spi_done_i`, `r1_spi_done_o` pulses, then GAP.
- **Abort and reset.**
  - r1 starts 0x5A and deasserts csb before grant → no 0x5A ever appears on `spi_out_o`.
  - `reset_i` during GNT0 → `flash_csb_o`=1 at the next edge and all pend/grant outputs are 0.

Source files
------------

// File: rtl/spi_flash_arbiter.sv
// Two-requester arbiter for one SPI byte engine and the flash CS#.
// Transaction-granular ownership, start-strobe capture/replay, and an enforced CS# high gap.
module spi_flash_arbiter #(
  parameter int unsigned CSB_HIGH_CYCLES = 2,
  parameter bit          FIXED_PRIO      = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       r0_csb_i,
  input  logic       r0_spi_start_i,
  input  logic [7:0] r0_spi_out_i,
  output logic [7:0] r0_spi_in_o,
  output logic       r0_spi_done_o,
  output logic       r0_spi_busy_o,
  output logic       r0_gnt_o,
  input  logic       r1_csb_i,
  input  logic       r1_spi_start_i,
  input  logic [7:0] r1_spi_out_i,
  output logic [7:0] r1_spi_in_o,
  output logic       r1_spi_done_o,
  output logic       r1_spi_busy_o,
  output logic       r1_gnt_o,
  output logic       spi_start_o,
  output logic [7:0] spi_out_o,
  input  logic [7:0] spi_in_i,
  input  logic       spi_done_i,
  input  logic       spi_busy_i,
  output logic       flash_csb_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, GAP} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       pend0_q, pend1_q;
  logic [7:0] pbyte0_q, pbyte1_q;

  logic req0, req1, pick1, rel0, rel1;

  assign req0  = ~r0_csb_i;
  assign req1  = ~r1_csb_i;
  // A tie goes to requester 1 only in round-robin mode after requester 0 was served last.
  assign pick1 = req1 & (~req0 | ((FIXED_PRIO == 1'b0) & ~last_q));
  // A release landing mid-byte is honoured once the engine reports done.
  assign rel0  = r0_csb_i & ~pend0_q & ~r0_spi_start_i & (~spi_busy_i | spi_done_i);
  assign rel1  = r1_csb_i & ~pend1_q & ~r1_spi_start_i & (~spi_busy_i | spi_done_i);

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      last_q   <= 1'b1;
      pend0_q  <= 1'b0;
      pend1_q  <= 1'b0;
      pbyte0_q <= 8'd0;
      pbyte1_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;

      if (state_q == GNT0 || r0_csb_i) begin
        pend0_q <= 1'b0;
      end else if (r0_spi_start_i && !pend0_q) begin
        pend0_q  <= 1'b1;
        pbyte0_q <= r0_spi_out_i;
      end

      if (state_q == GNT1 || r1_csb_i) begin
        pend1_q <= 1'b0;
      end else if (r1_spi_start_i && !pend1_q) begin
        pend1_q  <= 1'b1;
        pbyte1_q <= r1_spi_out_i;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = pick1 ? GNT1 : GNT0;
          last_d  = pick1;
        end
      end
      GNT0: begin
        if (rel0) begin
          state_d = GAP;
          cnt_d   = 8'(CSB_HIGH_CYCLES - 1);
        end
      end
      GNT1: begin
        if (rel1) begin
          state_d = GAP;
          cnt_d   = 8'(CSB_HIGH_CYCLES - 1);
        end
      end
      default: begin
        // The last gap cycle arbitrates directly so a waiting requester is granted without an extra IDLE cycle.
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (req0 || req1) begin
          state_d = pick1 ? GNT1 : GNT0;
          last_d  = pick1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    spi_start_o   = 1'b0;
    spi_out_o     = 8'd0;
    r0_spi_done_o = 1'b0;
    r1_spi_done_o = 1'b0;
    unique case (state_q)
      GNT0: begin
        spi_start_o   = pend0_q | r0_spi_start_i;
        spi_out_o     = pend0_q ? pbyte0_q : (r0_spi_start_i ? r0_spi_out_i : 8'd0);
        r0_spi_done_o = spi_done_i;
      end
      GNT1: begin
        spi_start_o   = pend1_q | r1_spi_start_i;
        spi_out_o     = pend1_q ? pbyte1_q : (r1_spi_start_i ? r1_spi_out_i : 8'd0);
        r1_spi_done_o = spi_done_i;
      end
      default: begin
      end
    endcase
  end

  assign r0_gnt_o      = (state_q == GNT0);
  assign r1_gnt_o      = (state_q == GNT1);
  assign flash_csb_o   = ~(r0_gnt_o | r1_gnt_o);
  assign r0_spi_busy_o = pend0_q | (r0_gnt_o & (spi_busy_i | spi_start_o));
  assign r1_spi_busy_o = pend1_q | (r1_gnt_o & (spi_busy_i | spi_start_o));
  assign r0_spi_in_o   = spi_in_i;
  assign r1_spi_in_o   = spi_in_i;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: fixed-priority and round-robin instances share stimulus;
// a scoreboard matches engine starts and grant order against expectations queued with the stimulus.
module tb_spi_flash_arbiter;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       reset_i;
  logic       r0_csb_i, r0_spi_start_i, r1_csb_i, r1_spi_start_i;
  logic [7:0] r0_spi_out_i, r1_spi_out_i, spi_in_i;
  logic       spi_done_i, spi_busy_i;

  logic [7:0] r0_spi_in [2];
  logic [7:0] r1_spi_in [2];
  logic       r0_done [2];
  logic       r1_done [2];
  logic       r0_busy [2];
  logic       r1_busy [2];
  logic       r0_gnt [2];
  logic       r1_gnt [2];
  logic       spi_start [2];
  logic [7:0] spi_out [2];
  logic       flash_csb [2];

  spi_flash_arbiter #(.CSB_HIGH_CYCLES(2), .FIXED_PRIO(1'b1)) u_fixed (
    .clk_i(clk_i), .reset_i(reset_i),
    .r0_csb_i(r0_csb_i), .r0_spi_start_i(r0_spi_start_i), .r0_spi_out_i(r0_spi_out_i),
    .r0_spi_in_o(r0_spi_in[0]), .r0_spi_done_o(r0_done[0]), .r0_spi_busy_o(r0_busy[0]), .r0_gnt_o(r0_gnt[0]),
    .r1_csb_i(r1_csb_i), .r1_spi_start_i(r1_spi_start_i), .r1_spi_out_i(r1_spi_out_i),
    .r1_spi_in_o(r1_spi_in[0]), .r1_spi_done_o(r1_done[0]), .r1_spi_busy_o(r1_busy[0]), .r1_gnt_o(r1_gnt[0]),
    .spi_start_o(spi_start[0]), .spi_out_o(spi_out[0]), .spi_in_i(spi_in_i),
    .spi_done_i(spi_done_i), .spi_busy_i(spi_busy_i), .flash_csb_o(flash_csb[0])
  );

  spi_flash_arbiter #(.CSB_HIGH_CYCLES(2), .FIXED_PRIO(1'b0)) u_rr (
    .clk_i(clk_i), .reset_i(reset_i),
    .r0_csb_i(r0_csb_i), .r0_spi_start_i(r0_spi_start_i), .r0_spi_out_i(r0_spi_out_i),
    .r0_spi_in_o(r0_spi_in[1]), .r0_spi_done_o(r0_done[1]), .r0_spi_busy_o(r0_busy[1]), .r0_gnt_o(r0_gnt[1]),
    .r1_csb_i(r1_csb_i), .r1_spi_start_i(r1_spi_start_i), .r1_spi_out_i(r1_spi_out_i),
    .r1_spi_in_o(r1_spi_in[1]), .r1_spi_done_o(r1_done[1]), .r1_spi_busy_o(r1_busy[1]), .r1_gnt_o(r1_gnt[1]),
    .spi_start_o(spi_start[1]), .spi_out_o(spi_out[1]), .spi_in_i(spi_in_i),
    .spi_done_i(spi_done_i), .spi_busy_i(spi_busy_i), .flash_csb_o(flash_csb[1])
  );

  // Instance under observation: 0 = fixed priority, 1 = round-robin.
  logic sel;
  logic [7:0] m_r0_in, m_r1_in, m_out;
  logic m_r0_done, m_r1_done, m_r0_busy, m_r1_busy, m_gnt0, m_gnt1, m_start, m_csb;
  assign m_r0_in   = r0_spi_in[sel];
  assign m_r1_in   = r1_spi_in[sel];
  assign m_r0_done = r0_done[sel];
  assign m_r1_done = r1_done[sel];
  assign m_r0_busy = r0_busy[sel];
  assign m_r1_busy = r1_busy[sel];
  assign m_gnt0    = r0_gnt[sel];
  assign m_gnt1    = r1_gnt[sel];
  assign m_start   = spi_start[sel];
  assign m_out     = spi_out[sel];
  assign m_csb     = flash_csb[sel];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard: {owner, byte} per engine start, and owner per new grant.
  logic [8:0] exp_byte_q[$];
  logic       exp_gnt_q[$];
  logic [1:0] prev_g = 2'b00;

  always @(negedge clk_i) begin
    if (reset_i) begin
      prev_g = 2'b00;
    end else begin
      if (m_start) begin
        if (exp_byte_q.size() == 0) check("sb_unexpected_start", 32'({m_start, m_out}), 0);
        else check("sb_byte", 32'({m_gnt1, m_out}), 32'(exp_byte_q.pop_front()));
      end
      if ({m_gnt1, m_gnt0} != 2'b00 && prev_g == 2'b00) begin
        if (exp_gnt_q.size() == 0) check("sb_unexpected_gnt", 32'({m_gnt1, m_gnt0}), 0);
        else check("sb_gnt_owner", 32'(m_gnt1), 32'(exp_gnt_q.pop_front()));
      end
      prev_g = {m_gnt1, m_gnt0};
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_csb(input logic who, input logic v);
    if (who) r1_csb_i = v;
    else r0_csb_i = v;
  endtask

  task automatic wait_gnt(output logic who);
    int n = 0;
    while (!(m_gnt0 || m_gnt1) && n < 30) begin
      cyc();
      n++;
    end
    check("rr_gnt_wait", 32'(m_gnt0 | m_gnt1), 1);
    who = m_gnt1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic who;
    sel = 1'b0;
    reset_i = 1'b1;
    r0_csb_i = 1'b1; r1_csb_i = 1'b1;
    r0_spi_start_i = 1'b0; r1_spi_start_i = 1'b0;
    r0_spi_out_i = 8'd0; r1_spi_out_i = 8'd0;
    spi_in_i = 8'd0; spi_done_i = 1'b0; spi_busy_i = 1'b0;
    cyc(); cyc();
    @(negedge clk_i);
    check("rst_csb", 32'(m_csb), 1);
    check("rst_start_out", 32'({m_start, m_out}), 0);
    check("rst_gnt", 32'({m_gnt1, m_gnt0}), 0);
    check("rst_busy", 32'({m_r1_busy, m_r0_busy}), 0);
    cyc();
    reset_i = 1'b0;

    // Boot alone: request and start in the same cycle, replayed one cycle later.
    r0_csb_i = 1'b0; r0_spi_start_i = 1'b1; r0_spi_out_i = 8'h03;
    exp_byte_q.push_back({1'b0, 8'h03}); exp_gnt_q.push_back(1'b0);
    @(negedge clk_i);
    check("boot_gnt_before", 32'(m_gnt0), 0);
    check("boot_csb_before", 32'(m_csb), 1);
    cyc(); r0_spi_start_i = 1'b0;
    @(negedge clk_i);
    check("boot_gnt", 32'(m_gnt0), 1);
    check("boot_csb", 32'(m_csb), 0);
    check("boot_start", 32'(m_start), 1);
    check("boot_busy", 32'(m_r0_busy), 1);
    cyc(); spi_busy_i = 1'b1;
    @(negedge clk_i);
    check("boot_no_start_out", 32'({m_start, m_out}), 0);
    check("boot_busy_shift", 32'(m_r0_busy), 1);
    cyc(); spi_busy_i = 1'b0; spi_done_i = 1'b1; spi_in_i = 8'h9C;
    @(negedge clk_i);
    check("boot_done", 32'(m_r0_done), 1);
    check("boot_in", 32'(m_r0_in), 32'h9C);
    check("boot_r1_in", 32'(m_r1_in), 32'h9C);
    check("boot_r1_no_done", 32'(m_r1_done), 0);
    cyc(); spi_done_i = 1'b0; r0_csb_i = 1'b1;
    @(negedge clk_i);
    check("boot_rel_csb", 32'(m_csb), 0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      @(negedge clk_i);
      check("boot_gap_csb", 32'(m_csb), 1);
    end
    cyc(); cyc();

    // Simultaneous requests, fixed priority: r0 first, r1's captured byte replayed after the gap.
    r0_csb_i = 1'b0; r0_spi_start_i = 1'b1; r0_spi_out_i = 8'h11;
    r1_csb_i = 1'b0; r1_spi_start_i = 1'b1; r1_spi_out_i = 8'hA5;
    exp_byte_q.push_back({1'b0, 8'h11}); exp_byte_q.push_back({1'b1, 8'hA5});
    exp_gnt_q.push_back(1'b0); exp_gnt_q.push_back(1'b1);
    cyc(); r0_spi_start_i = 1'b0; r1_spi_start_i = 1'b0;
    @(negedge clk_i);
    check("prio_gnt0", 32'(m_gnt0), 1);
    check("prio_r1_pend_busy", 32'(m_r1_busy), 1);
    check("prio_r1_no_gnt", 32'(m_gnt1), 0);
    cyc(); spi_busy_i = 1'b1;
    cyc(); spi_busy_i = 1'b0; spi_done_i = 1'b1;
    @(negedge clk_i);
    check("prio_r0_done", 32'(m_r0_done), 1);
    check("prio_r1_no_done", 32'(m_r1_done), 0);
    cyc(); spi_done_i = 1'b0; r0_csb_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      @(negedge clk_i);
      check("prio_gap_csb", 32'(m_csb), 1);
      check("prio_gap_no_gnt1", 32'(m_gnt1), 0);
    end
    cyc();
    @(negedge clk_i);
    check("prio_gnt1", 32'(m_gnt1), 1);
    check("prio_gnt1_csb", 32'(m_csb), 0);
    check("prio_replay_start", 32'(m_start), 1);
    cyc(); r1_csb_i = 1'b1;
    cyc(); cyc(); cyc(); cyc();

    // Release mid-byte: CS# stays asserted until done.
    r1_csb_i = 1'b0; r1_spi_start_i = 1'b1; r1_spi_out_i = 8'hC3;
    exp_byte_q.push_back({1'b1, 8'hC3}); exp_gnt_q.push_back(1'b1);
    cyc(); r1_spi_start_i = 1'b0;
    cyc(); spi_busy_i = 1'b1; r1_csb_i = 1'b1;
    @(negedge clk_i);
    check("mid_csb_hold", 32'(m_csb), 0);
    cyc();
    @(negedge clk_i);
    check("mid_gnt_hold", 32'({m_gnt1, m_csb}), 32'b10);
    cyc(); spi_busy_i = 1'b0; spi_done_i = 1'b1; spi_in_i = 8'h6E;
    @(negedge clk_i);
    check("mid_done", 32'({m_r1_done, m_csb}), 32'b10);
    check("mid_in", 32'(m_r1_in), 32'h6E);
    cyc(); spi_done_i = 1'b0;
    @(negedge clk_i);
    check("mid_gap", 32'({m_gnt1, m_csb}), 32'b01);
    cyc(); cyc(); cyc();

    // Abort: r1 captures 0x5A while r0 owns the engine, then withdraws.
    r0_csb_i = 1'b0; r0_spi_start_i = 1'b1; r0_spi_out_i = 8'h22;
    exp_byte_q.push_back({1'b0, 8'h22}); exp_gnt_q.push_back(1'b0);
    cyc(); r0_spi_start_i = 1'b0;
    r1_csb_i = 1'b0; r1_spi_start_i = 1'b1; r1_spi_out_i = 8'h5A;
    cyc(); r1_spi_start_i = 1'b0;
    @(negedge clk_i);
    check("abort_pend_busy", 32'({m_r1_busy, m_gnt1}), 32'b10);
    cyc(); r1_csb_i = 1'b1;
    cyc();
    @(negedge clk_i);
    check("abort_cleared", 32'(m_r1_busy), 0);
    r0_csb_i = 1'b1;
    for (int k = 0; k < 5; k++) cyc();

    // Reset while r0 owns the engine with a byte in flight.
    r0_csb_i = 1'b0; r0_spi_start_i = 1'b1; r0_spi_out_i = 8'h44;
    exp_byte_q.push_back({1'b0, 8'h44}); exp_gnt_q.push_back(1'b0);
    cyc(); r0_spi_start_i = 1'b0;
    cyc(); spi_busy_i = 1'b1; reset_i = 1'b1; r0_csb_i = 1'b1;
    r1_csb_i = 1'b0; r1_spi_start_i = 1'b1; r1_spi_out_i = 8'h77;
    @(negedge clk_i);
    check("rst_mid_before_edge", 32'(m_csb), 0);
    cyc(); spi_busy_i = 1'b0; spi_done_i = 1'b1; r1_spi_start_i = 1'b0; r1_csb_i = 1'b1;
    @(negedge clk_i);
    check("rst_mid_csb", 32'(m_csb), 1);
    check("rst_mid_gnt", 32'({m_gnt1, m_gnt0}), 0);
    check("rst_mid_busy", 32'({m_r1_busy, m_r0_busy}), 0);
    check("rst_mid_done", 32'({m_r1_done, m_r0_done}), 0);
    check("rst_mid_start", 32'(m_start), 0);
    cyc(); spi_done_i = 1'b0;

    // Round-robin: both requesters keep re-requesting; grants alternate 0,1,0.
    sel = 1'b1;
    cyc(); reset_i = 1'b0;
    r0_csb_i = 1'b0; r1_csb_i = 1'b0;
    exp_gnt_q.push_back(1'b0); exp_gnt_q.push_back(1'b1); exp_gnt_q.push_back(1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_gnt(who);
      check("rr_order", 32'(who), 32'(i % 2));
      cyc(); cyc();
      set_csb(who, 1'b1);
      cyc();
      if (i < 2) set_csb(who, 1'b0);
    end
    r0_csb_i = 1'b1; r1_csb_i = 1'b1;
    for (int k = 0; k < 5; k++) cyc();

    check("sb_bytes_drained", 32'(exp_byte_q.size()), 0);
    check("sb_gnts_drained", 32'(exp_gnt_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
